bbox_overlay_ctrl: RTL and testbench

//  Sequencer for the detection-overlay stage of the face-detection pipeline. On start it derives the
//  8-aligned square size of the detection map, raster-scans the map (row stride = size) and, for every

---
 rtl/bbox_pkg.sv | 25 ++
 rtl/bbox_raster_addr_gen.sv | 55 +++++
 rtl/bbox_overlay_ctrl.sv | 125 ++++++++++++
 tb/tb_bbox_overlay_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bbox_pkg : shared constants, FSM state type and alignment helper for the   |
// |            detection-overlay sequencer.          Revision: 1.0             |
// +----------------------------------------------------------------------------+
package bbox_pkg;

    localparam int unsigned ALIGN = 8;
    localparam int unsigned MARK  = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SCAN  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Rounds v up to the next multiple of a power-of-two granule.
    function automatic logic [31:0] align_up(input logic [31:0] v, input logic [31:0] granule);
        return (v + granule - 32'd1) & ~(granule - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bbox_raster_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bbox_raster_addr_gen : column/row raster counters with two stride-based    |
// |                        row bases and a last-pixel flag. Revision: 1.0      |
// +----------------------------------------------------------------------------+
module bbox_raster_addr_gen #(
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              advance,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [DIM_W-1:0]  stride,
    output logic [ADDR_W-1:0] mask_addr,
    output logic [ADDR_W-1:0] img_addr,
    output logic              last
);

    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_mask_base;
    logic [ADDR_W-1:0] r_img_base;
    logic              w_col_end;
    logic              w_row_end;

    assign w_col_end = (r_col == width  - DIM_W'(1));
    assign w_row_end = (r_row == height - DIM_W'(1));
    assign last      = w_col_end && w_row_end;
    assign mask_addr = r_mask_base + ADDR_W'(r_col);
    assign img_addr  = r_img_base  + ADDR_W'(r_col);

    // Row bases step by their own stride so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (reset || init) begin
            r_col       <= '0;
            r_row       <= '0;
            r_mask_base <= '0;
            r_img_base  <= '0;
        end else if (advance) begin
            if (w_col_end) begin
                r_col       <= '0;
                r_row       <= r_row + DIM_W'(1);
                r_mask_base <= r_mask_base + ADDR_W'(stride);
                r_img_base  <= r_img_base  + ADDR_W'(width);
            end else begin
                r_col       <= r_col + DIM_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bbox_overlay_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bbox_overlay_ctrl : scans the padded detection map and marks detected      |
// |                     pixels in the original image buffer. Revision: 1.0     |
// +----------------------------------------------------------------------------+
module bbox_overlay_ctrl
    import bbox_pkg::*;
#(
    parameter int          DIM_W  = 16,
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter int unsigned ALIGN  = bbox_pkg::ALIGN,
    parameter int unsigned MARK   = bbox_pkg::MARK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic              busy,
    output logic              done,
    output logic [DIM_W-1:0]  size,
    output logic              long_axis,
    output logic              mask_rd_en,
    output logic [ADDR_W-1:0] mask_addr,
    input  logic [DATA_W-1:0] mask_rd_data,
    output logic              img_wr_en,
    output logic [ADDR_W-1:0] img_wr_addr,
    output logic [DATA_W-1:0] img_wr_data,
    input  logic              img_wr_ready
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIM_W-1:0]  r_width;
    logic [DIM_W-1:0]  r_height;
    logic [DIM_W-1:0]  r_size;
    logic              r_long_axis;
    logic [DIM_W-1:0]  w_pw;
    logic [DIM_W-1:0]  w_ph;
    logic              w_stall;
    logic              w_rd_fire;
    logic              w_last;
    logic [ADDR_W-1:0] w_gen_img_addr;
    logic              r_d_valid;
    logic [ADDR_W-1:0] r_d_addr;
    logic              r_w_en;
    logic [ADDR_W-1:0] r_w_addr;

    assign w_pw      = DIM_W'(align_up(32'(r_width),  32'(ALIGN)));
    assign w_ph      = DIM_W'(align_up(32'(r_height), 32'(ALIGN)));
    assign w_stall   = r_w_en && !img_wr_ready;
    assign w_rd_fire = (r_state == SCAN) && !w_stall;

    assign busy        = (r_state == SETUP) || (r_state == SCAN) || (r_state == DRAIN);
    assign done        = (r_state == DONE);
    assign size        = r_size;
    assign long_axis   = r_long_axis;
    assign mask_rd_en  = w_rd_fire;
    assign img_wr_en   = r_w_en;
    assign img_wr_addr = r_w_addr;
    assign img_wr_data = r_w_en ? DATA_W'(MARK) : '0;

    bbox_raster_addr_gen #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .init      (r_state == SETUP),
        .advance   (w_rd_fire),
        .width     (r_width),
        .height    (r_height),
        .stride    (r_size),
        .mask_addr (mask_addr),
        .img_addr  (w_gen_img_addr),
        .last      (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (start) w_state_nxt = SETUP;
            // An empty frame still passes through DRAIN, giving it the same done spacing.
            SETUP: w_state_nxt = ((r_width == '0) || (r_height == '0)) ? DRAIN : SCAN;
            SCAN:  if (w_rd_fire && w_last) w_state_nxt = DRAIN;
            DRAIN: if (!r_d_valid && (!r_w_en || img_wr_ready)) w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_size      <= '0;
            r_long_axis <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_addr    <= '0;
            r_w_en      <= 1'b0;
            r_w_addr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && start) begin
                r_width  <= width;
                r_height <= height;
            end
            if (r_state == SETUP) begin
                r_size      <= (w_pw > w_ph) ? w_pw : w_ph;
                r_long_axis <= (w_pw > w_ph);
            end
            // A stalled write freezes D and W; the RAM keeps its dout, so D re-samples it.
            if (!w_stall) begin
                r_d_valid <= w_rd_fire;
                r_d_addr  <= w_gen_img_addr;
                r_w_en    <= r_d_valid && (mask_rd_data != '0);
                r_w_addr  <= r_d_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bbox_overlay_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bbox_overlay_ctrl : directed self-checking bench for bbox_overlay_ctrl. |
// |                                                   Revision: 1.0            |
// +----------------------------------------------------------------------------+
module tb_bbox_overlay_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] width = '0;
    logic [15:0] height = '0;
    logic        busy;
    logic        done;
    logic [15:0] size;
    logic        long_axis;
    logic        mask_rd_en;
    logic [31:0] mask_addr;
    logic [31:0] mask_rd_data = '0;
    logic        img_wr_en;
    logic [31:0] img_wr_addr;
    logic [31:0] img_wr_data;
    logic        img_wr_ready = 1'b1;

    logic [31:0] mask_mem [0:255];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_addr_q[$];
    int          wr_data_q[$];

    bbox_overlay_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .width        (width),
        .height       (height),
        .busy         (busy),
        .done         (done),
        .size         (size),
        .long_axis    (long_axis),
        .mask_rd_en   (mask_rd_en),
        .mask_addr    (mask_addr),
        .mask_rd_data (mask_rd_data),
        .img_wr_en    (img_wr_en),
        .img_wr_addr  (img_wr_addr),
        .img_wr_data  (img_wr_data),
        .img_wr_ready (img_wr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mask RAM: one-cycle read latency, output held while not reading.
    always @(posedge clk) if (mask_rd_en) mask_rd_data <= mask_mem[mask_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic fill_mask(input logic [31:0] v);
        for (int i = 0; i < 256; i++) mask_mem[i] = v;
    endtask

    // Launches one frame and watches it until done; done_at stays -1 on timeout.
    task automatic run_frame(input int w, input int h, input bit stall_en, input bit pulse_again,
                             output int done_at, output int first_rd, output int n_rd);
        int t0;
        int stall_left;
        @(negedge clk);
        width  = 16'(w);
        height = 16'(h);
        start  = 1'b1;
        t0     = cyc;
        wr_addr_q.delete();
        wr_data_q.delete();
        n_rd = 0; first_rd = -1; done_at = -1;
        stall_left = stall_en ? 3 : 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            start = pulse_again && (k == 0);
            if (stall_left > 0 && wr_addr_q.size() == 1 && img_wr_en) begin
                img_wr_ready = 1'b0;
                stall_left--;
            end else begin
                img_wr_ready = 1'b1;
            end
            #1;
            if (mask_rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc - t0;
            end
            if (img_wr_en && img_wr_ready) begin
                wr_addr_q.push_back(int'(img_wr_addr));
                wr_data_q.push_back(int'(img_wr_data));
            end
            if (done) begin
                done_at = cyc - t0;
                break;
            end
        end
        start = 1'b0;
        img_wr_ready = 1'b1;
    endtask

    task automatic check_seq_writes(input string tag, input int n);
        check({tag, " write count"}, wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), wr_addr_q[i], i);
            check($sformatf("%s data[%0d]", tag, i), wr_data_q[i], 255);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " mask_rd_en"}, mask_rd_en, 0);
        check({tag, " img_wr_en"}, img_wr_en, 0);
        check({tag, " size"}, size, 0);
        check({tag, " long_axis"}, long_axis, 0);
        check({tag, " mask_addr"}, mask_addr, 0);
        check({tag, " img_wr_addr"}, img_wr_addr, 0);
    endtask

    initial begin
        int done_at, first_rd, n_rd, busy_seen;

        fill_mask('0);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // 5x3, single detection at map word 17 = (r2,c1) -> image 2*5+1
        fill_mask('0);
        mask_mem[17] = 32'h00A0_0000;
        run_frame(5, 3, 1'b0, 1'b0, done_at, first_rd, n_rd);
        check("t1 size", size, 8);
        check("t1 long_axis", long_axis, 0);
        check("t1 first read", first_rd, 2);
        check("t1 reads", n_rd, 15);
        check("t1 write count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) begin
            check("t1 write addr", wr_addr_q[0], 11);
            check("t1 write data", wr_data_q[0], 255);
        end
        check("t1 done latency", done_at, 19);

        // 12x4 pads to 16x8: width is the long axis
        for (int i = 0; i < 256; i++) mask_mem[i] = 32'(i + 1);
        run_frame(12, 4, 1'b0, 1'b0, done_at, first_rd, n_rd);
        check("t2 size", size, 16);
        check("t2 long_axis", long_axis, 1);
        check("t2 reads", n_rd, 48);
        check_seq_writes("t2", 48);
        check("t2 done latency", done_at, 52);

        // 8x8 all-zero mask: reads only
        fill_mask('0);
        run_frame(8, 8, 1'b0, 1'b0, done_at, first_rd, n_rd);
        check("t3 size", size, 8);
        check("t3 reads", n_rd, 64);
        check("t3 write count", wr_addr_q.size(), 0);
        check("t3 done latency", done_at, 68);

        // 5x3 all-ones with a 3-cycle write stall on the second write
        fill_mask(32'h1);
        run_frame(5, 3, 1'b1, 1'b0, done_at, first_rd, n_rd);
        check("t4 reads", n_rd, 15);
        check_seq_writes("t4", 15);
        check("t4 done latency", done_at, 22);

        // zero width, second start pulse while busy
        run_frame(0, 7, 1'b0, 1'b1, done_at, first_rd, n_rd);
        check("t5 reads", n_rd, 0);
        check("t5 write count", wr_addr_q.size(), 0);
        check("t5 done latency", done_at, 3);
        check("t5 size", size, 8);
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("t5 restart ignored", busy_seen, 0);

        // reset in the middle of a scan
        fill_mask(32'h1);
        @(negedge clk);
        width = 16'd8; height = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("t6 scanning", mask_rd_en, 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6 reset");
        reset = 1'b0;
        @(negedge clk);
        check("t6 stays idle", busy, 0);

        fill_mask('0);
        mask_mem[17] = 32'h0000_0001;
        run_frame(5, 3, 1'b0, 1'b0, done_at, first_rd, n_rd);
        check("t7 write count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) check("t7 write addr", wr_addr_q[0], 11);
        check("t7 done latency", done_at, 19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
